// File: rtl/spwm_gate_driver_if.sv
// Signal bundle between the carrier/sine-lookup side and one SPWM inverter leg.
// The master drives carrier, reference and control; the slave returns the gates.
interface spwm_gate_driver_if;
    logic       enable;
    logic [5:0] carrier;
    logic [5:0] mod_ref;
    logic       fault;
    logic       gate_hi;
    logic       gate_lo;
    logic       sample_stb;
    logic       fault_latched;

    modport master (
        output enable, carrier, mod_ref, fault,
        input  gate_hi, gate_lo, sample_stb, fault_latched
    );

    modport slave (
        input  enable, carrier, mod_ref, fault,
        output gate_hi, gate_lo, sample_stb, fault_latched
    );
endinterface

// File: rtl/spwm_gate_driver.sv
// One SPWM inverter leg: regular-sampled reference vs triangle carrier, dead-time gate FSM.
// Optional latching fault shutdown is compiled in with SPWM_FAULT_LATCH_EN.
module spwm_gate_driver #(
    parameter int DEAD_CYCLES  = 4,
    parameter int CARRIER_PEAK = 32
) (
    input  logic              clk,
    input  logic              reset,
    spwm_gate_driver_if.slave bus
);
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DEAD  = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [5:0] PEAK      = 6'(CARRIER_PEAK);
    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [3:0] dead_cnt_reg, dead_cnt_next;
    logic [5:0] ref_q_reg;
    logic       sample_stb_reg;
    logic       at_extreme;
    logic       demand;
    logic       fault_hit;

    assign at_extreme = (bus.carrier == 6'd0) || (bus.carrier == PEAK);
    // Full-scale reference pins the leg high even when the carrier touches its peak.
    assign demand     = (ref_q_reg == PEAK) || (ref_q_reg > bus.carrier);

`ifdef SPWM_FAULT_LATCH_EN
    assign fault_hit = bus.fault || (state_reg == ST_FAULT);
`else
    logic unused_fault;
    assign unused_fault = bus.fault;
    assign fault_hit    = 1'b0;
`endif

    // Regular sampling: the reference is only reloaded at the carrier extremes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_q_reg      <= 6'd0;
            sample_stb_reg <= 1'b0;
        end else begin
            sample_stb_reg <= at_extreme;
            if (at_extreme) begin
                ref_q_reg <= (bus.mod_ref > PEAK) ? PEAK : bus.mod_ref;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_OFF;
            dead_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            dead_cnt_reg <= dead_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        dead_cnt_next = dead_cnt_reg;
        if (fault_hit) begin
            state_next = ST_FAULT;
        end else if (!bus.enable) begin
            state_next = ST_OFF;
        end else begin
            unique case (state_reg)
                ST_OFF: begin
                    state_next    = ST_DEAD;
                    dead_cnt_next = DEAD_LOAD;
                end
                ST_DEAD: begin
                    // Exit side is chosen at expiry; reversals mid-gap do not restart it.
                    if (dead_cnt_reg == 4'd0) begin
                        state_next = demand ? ST_HI : ST_LO;
                    end else begin
                        dead_cnt_next = dead_cnt_reg - 4'd1;
                    end
                end
                ST_HI: begin
                    if (!demand) begin
                        state_next    = ST_DEAD;
                        dead_cnt_next = DEAD_LOAD;
                    end
                end
                ST_LO: begin
                    if (demand) begin
                        state_next    = ST_DEAD;
                        dead_cnt_next = DEAD_LOAD;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                end
            endcase
        end
    end

    // Gates decode straight from the state register so they cannot glitch.
    always_comb begin
        bus.gate_hi       = (state_reg == ST_HI);
        bus.gate_lo       = (state_reg == ST_LO);
        bus.sample_stb    = sample_stb_reg;
`ifdef SPWM_FAULT_LATCH_EN
        bus.fault_latched = (state_reg == ST_FAULT);
`else
        bus.fault_latched = 1'b0;
`endif
    end
endmodule

// File: tb/tb_spwm_gate_driver.sv
// Bench for spwm_gate_driver: directed and random reference/enable traffic against a
// time-stamped behavioural leg model; works with or without SPWM_FAULT_LATCH_EN.
module tb_spwm_gate_driver;
    localparam int D  = 4;
    localparam int PK = 32;
`ifdef SPWM_FAULT_LATCH_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    spwm_gate_driver_if bus ();

    spwm_gate_driver #(.DEAD_CYCLES(D), .CARRIER_PEAK(PK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: 0 off, 1 dead gap, 2 high side, 3 low side, 4 fault
    int         m_mode;
    int         exit_edge;
    int         edge_n = 0;
    logic [5:0] refq_m;
    bit         stb_m;
    int         phase = 0;
    int         last_side;
    int         lowlow_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h required %0h (edge %0d)", tag, obs, exp, edge_n);
    endtask

    function automatic logic [5:0] tri_at(input int p);
        int m;
        m = p % 64;
        return 6'((m <= PK) ? m : 64 - m);
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        refq_m     = 6'd0;
        stb_m      = 1'b0;
        last_side  = 0;
        lowlow_run = 0;
    endtask

    task automatic cycle();
        logic [5:0] car;
        bit dem, ext;
        int side;
        car = tri_at(phase);
        bus.carrier = car;
        @(posedge clk);
        edge_n++;
        dem = (refq_m == 6'(PK)) || (refq_m > car);
        ext = (car == 6'd0) || (car == 6'(PK));
        if (FAULT_EN && bus.fault) m_mode = 4;
        else if (m_mode == 4) m_mode = 4;
        else if (!bus.enable) m_mode = 0;
        else begin
            case (m_mode)
                0: begin m_mode = 1; exit_edge = edge_n + D; end
                1: if (edge_n == exit_edge) m_mode = dem ? 2 : 3;
                2: if (!dem) begin m_mode = 1; exit_edge = edge_n + D; end
                3: if (dem)  begin m_mode = 1; exit_edge = edge_n + D; end
                default: m_mode = 0;
            endcase
        end
        stb_m = ext;
        if (ext) refq_m = (bus.mod_ref > 6'(PK)) ? 6'(PK) : bus.mod_ref;
        #1;
        check("outputs", {28'd0, bus.gate_hi, bus.gate_lo, bus.sample_stb, bus.fault_latched},
              {28'd0, m_mode == 2, m_mode == 3, stb_m, m_mode == 4});
        check("overlap", {31'd0, bus.gate_hi & bus.gate_lo}, 32'd0);
        if (!bus.gate_hi && !bus.gate_lo) lowlow_run++;
        else begin
            side = bus.gate_hi ? 1 : 2;
            if (last_side != 0 && side != last_side)
                check("deadgap", {31'd0, lowlow_run >= D}, 32'd1);
            lowlow_run = 0;
            last_side  = side;
        end
        phase++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.carrier   = 6'd0;
        bus.mod_ref   = 6'd0;
        bus.fault     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_vals", {28'd0, bus.gate_hi, bus.gate_lo, bus.sample_stb, bus.fault_latched}, 32'd0);
        reset = 1'b0;

        // Mid-scale reference: about half duty around each carrier crossing
        bus.mod_ref = 6'd16;
        bus.enable  = 1'b1;
        run(128);

        // Zero reference holds the low side; over-range reference clamps to full high
        bus.mod_ref = 6'd0;
        run(128);
        check("ref0_lo", {31'd0, bus.gate_lo}, 32'd1);
        bus.mod_ref = 6'd40;
        run(128);
        check("ref40_hi", {31'd0, bus.gate_hi}, 32'd1);

        // Reference change mid-slope waits for the next extreme
        bus.mod_ref = 6'd10;
        run(64 - (phase % 64) + 16);
        bus.mod_ref = 6'd25;
        run(80);

        // Random reference and enable toggles over ten carrier periods
        for (int i = 0; i < 640; i++) begin
            if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 7) == 0) bus.mod_ref = 6'($urandom_range(0, 63));
            cycle();
        end

        // Asynchronous reset mid high-side pulse
        bus.enable  = 1'b1;
        bus.mod_ref = 6'd40;
        for (int i = 0; i < 200 && !bus.gate_hi; i++) cycle();
        check("reach_hi", {31'd0, bus.gate_hi}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", {30'd0, bus.gate_hi, bus.gate_lo}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run(80);

        // Single-cycle fault pulse while driving the high side
        for (int i = 0; i < 200 && !bus.gate_hi; i++) cycle();
        check("reach_hi2", {31'd0, bus.gate_hi}, 32'd1);
        bus.fault = 1'b1;
        cycle();
        bus.fault = 1'b0;
        run(40);
        check("fault_flag", {31'd0, bus.fault_latched}, {31'd0, FAULT_EN});
        check("fault_gate", {31'd0, bus.gate_hi}, {31'd0, !FAULT_EN});
        do_reset();
        run(70);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
